// File: rtl/sextium_avalon_master_if.sv
// rtl/sextium_avalon_master_if.sv - CPU-side and Avalon-MM-side signal bundle for sextium_avalon_master
interface sextium_avalon_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  // CPU request side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;

  // Avalon-MM master side
  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_ack, cpu_rdata, cpu_busy,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_ack, cpu_rdata, cpu_busy,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sextium_avalon_master.sv
// rtl/sextium_avalon_master.sv - CPU to Avalon-MM single-transaction master; SEXTIUM_AVM_PIPELINED_READ_EN enables variable-latency reads
module sextium_avalon_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  sextium_avalon_master_if.master  bus
);
  localparam int BE_W = DATA_W / 8;

`ifdef SEXTIUM_AVM_PIPELINED_READ_EN
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP, S_ACK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ACK} state_t;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] writedata_q;
  logic [BE_W-1:0]   byteenable_q;
  logic              read_q;
  logic              write_q;
  logic              ack_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  // Transaction FSM; every output is a register so the bus sees glitch-free commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (bus.cpu_req) begin
            address_q    <= bus.cpu_addr;
            writedata_q  <= bus.cpu_wdata;
            // Reads always fetch the full word
            byteenable_q <= bus.cpu_we ? bus.cpu_be : '1;
            write_q      <= bus.cpu_we;
            read_q       <= ~bus.cpu_we;
            busy_q       <= 1'b1;
            state_q      <= S_CMD;
          end
        end
        S_CMD: begin
          // Command is held untouched for as long as the slave stalls
          if (!bus.avm_waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef SEXTIUM_AVM_PIPELINED_READ_EN
            if (read_q) begin
              state_q <= S_RESP;
            end else begin
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end
`else
            if (read_q) begin
              rdata_q <= bus.avm_readdata;
            end
            ack_q   <= 1'b1;
            state_q <= S_ACK;
`endif
          end
        end
`ifdef SEXTIUM_AVM_PIPELINED_READ_EN
        S_RESP: begin
          if (bus.avm_readdatavalid) begin
            rdata_q <= bus.avm_readdata;
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end
        end
`endif
        S_ACK: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.avm_address    = address_q;
  assign bus.avm_writedata  = writedata_q;
  assign bus.avm_byteenable = byteenable_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.cpu_ack        = ack_q;
  assign bus.cpu_busy       = busy_q;
  assign bus.cpu_rdata      = rdata_q;
endmodule

// File: tb/tb_sextium_avalon_master.sv
// tb/tb_sextium_avalon_master.sv - scoreboard bench for sextium_avalon_master
module tb_sextium_avalon_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sextium_avalon_master_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  sextium_avalon_master #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          ws;
  } cmd_t;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];

  int checks = 0;
  int failures = 0;
  int acks_seen = 0;
  int rv_lat = 3;
  logic [15:0] rd_cfg = 16'h0000;
  logic [15:0] model_rdata = 16'h0000;
  logic spur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model plus command checker: stalls per expected entry, checks command stability every cycle
  int   wcnt = 0;
  int   rv_cnt = 0;
  int   cmd_cycles = 0;
  logic in_cmd = 1'b0;
  always @(negedge clk) begin
    cmd_t e;
    bus.avm_readdatavalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) bus.avm_readdatavalid = 1'b1;
    end
    if (spur) bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata = rd_cfg;
    if (bus.avm_read || bus.avm_write) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_unexpected", 1, 0);
        bus.avm_waitrequest = 1'b0;
      end else begin
        e = cmd_q[0];
        if (!in_cmd) begin
          in_cmd = 1'b1;
          wcnt = e.ws;
          cmd_cycles = 0;
        end
        cmd_cycles++;
        bus.avm_waitrequest = (wcnt > 0);
        if (wcnt > 0) wcnt--;
        chk("cmd_write", {31'd0, bus.avm_write}, {31'd0, e.we});
        chk("cmd_read", {31'd0, bus.avm_read}, {31'd0, ~e.we});
        chk("cmd_addr", {16'd0, bus.avm_address}, {16'd0, e.addr});
        chk("cmd_be", {30'd0, bus.avm_byteenable}, {30'd0, e.be});
        if (e.we) chk("cmd_wdata", {16'd0, bus.avm_writedata}, {16'd0, e.wdata});
        if (!bus.avm_waitrequest) begin
          chk("cmd_cycles", cmd_cycles, e.ws + 1);
          void'(cmd_q.pop_front());
          in_cmd = 1'b0;
          if (bus.avm_read) rv_cnt = rv_lat;
        end
      end
    end else begin
      in_cmd = 1'b0;
      bus.avm_waitrequest = 1'b0;
    end
  end

  // Completion monitor: latency in busy cycles, returned data, idle gap between transactions
  int   lat = 0;
  int   idle_run = 0;
  int   last_idle_run = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    ack_t a;
    if (bus.cpu_busy) begin
      if (!prev_busy) last_idle_run = idle_run;
      idle_run = 0;
      lat++;
    end else begin
      idle_run++;
      lat = 0;
    end
    prev_busy = bus.cpu_busy;
    if (bus.cpu_ack) begin
      acks_seen++;
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        a = ack_q.pop_front();
        chk("ack_latency", lat, a.lat);
        chk("ack_rdata", {16'd0, bus.cpu_rdata}, {16'd0, a.rdata});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input int ws, input logic [15:0] rdval);
    cmd_t c;
    ack_t a;
    int   el;
    c.we = we; c.addr = addr; c.wdata = wdata; c.be = we ? be : 2'b11; c.ws = ws;
    cmd_q.push_back(c);
    el = 2 + ws;
`ifdef SEXTIUM_AVM_PIPELINED_READ_EN
    if (!we) el = el + rv_lat;
`endif
    if (!we) model_rdata = rdval;
    a.lat = el; a.rdata = model_rdata;
    ack_q.push_back(a);
    rd_cfg = rdval;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_be = be;
  endtask

  task automatic scramble(input logic req);
    drive_cpu(req, ~bus.cpu_we, 16'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic wait_acks(input int target);
    for (int k = 0; k < 400 && acks_seen < target; k++) tick();
    if (acks_seen < target) chk("ack_timeout", acks_seen, target);
  endtask

  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input int ws, input logic [15:0] rdval);
    int n;
    n = acks_seen;
    push_exp(we, addr, wdata, be, ws, rdval);
    drive_cpu(1'b1, we, addr, wdata, be);
    tick();
    chk("busy_rise", {31'd0, bus.cpu_busy}, 1);
    scramble(1'b0);
    wait_acks(n + 1);
    tick();
  endtask

  initial begin
    int n;
    drive_cpu(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();
    tick();
    chk("rst_read", {31'd0, bus.avm_read}, 0);
    chk("rst_write", {31'd0, bus.avm_write}, 0);
    chk("rst_addr", {16'd0, bus.avm_address}, 0);
    chk("rst_wdata", {16'd0, bus.avm_writedata}, 0);
    chk("rst_be", {30'd0, bus.avm_byteenable}, 0);
    chk("rst_ack", {31'd0, bus.cpu_ack}, 0);
    chk("rst_busy", {31'd0, bus.cpu_busy}, 0);
    chk("rst_rdata", {16'd0, bus.cpu_rdata}, 0);

    // First request presented as reset releases: sampled on the very next edge
    reset_n = 1'b1;
    do_txn(1'b1, 16'h1234, 16'hBEEF, 2'b10, 0, 16'h0000);
    do_txn(1'b0, 16'h0040, 16'h0000, 2'b01, 4, 16'hA5A5);
    do_txn(1'b1, 16'h00FF, 16'h1357, 2'b01, 2, 16'h9999);
    chk("rdata_after_write", {16'd0, bus.cpu_rdata}, {16'd0, model_rdata});
    do_txn(1'b0, 16'h0002, 16'h0000, 2'b00, 0, 16'h5A5A);

    // Spurious readdatavalid while idle must not touch cpu_rdata
    rd_cfg = 16'h1111;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("rdata_spurious", {16'd0, bus.cpu_rdata}, {16'd0, model_rdata});

    // cpu_req held high with alternating direction
    n = acks_seen;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 100 && bus.cpu_busy; k++) tick();
      push_exp(i[0] == 1'b0, 16'h0200 + 16'(i), 16'hD000 + 16'(i),
               i[0] ? 2'b01 : 2'b10, i % 2, 16'h7000 + 16'(i));
      drive_cpu(1'b1, i[0] == 1'b0, 16'h0200 + 16'(i), 16'hD000 + 16'(i), i[0] ? 2'b01 : 2'b10);
      tick();
      chk("b2b_busy_rise", {31'd0, bus.cpu_busy}, 1);
      if (i > 0) chk("b2b_idle_gap", last_idle_run, 1);
      scramble(i < 3);
    end
    wait_acks(n + 4);
    tick();

    // Reset while the slave stalls a read: outputs clear at once, no ack follows
    begin
      cmd_t c;
      c.we = 1'b0; c.addr = 16'h0777; c.wdata = 16'h0; c.be = 2'b11; c.ws = 1000;
      cmd_q.push_back(c);
    end
    drive_cpu(1'b1, 1'b0, 16'h0777, 16'h0, 2'b00);
    tick();
    scramble(1'b0);
    tick();
    tick();
    chk("pre_rst_read", {31'd0, bus.avm_read}, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_read", {31'd0, bus.avm_read}, 0);
    chk("mid_rst_write", {31'd0, bus.avm_write}, 0);
    chk("mid_rst_addr", {16'd0, bus.avm_address}, 0);
    chk("mid_rst_be", {30'd0, bus.avm_byteenable}, 0);
    chk("mid_rst_busy", {31'd0, bus.cpu_busy}, 0);
    chk("mid_rst_ack", {31'd0, bus.cpu_ack}, 0);
    chk("mid_rst_rdata", {16'd0, bus.cpu_rdata}, 0);
    cmd_q.delete();
    model_rdata = 16'h0000;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    do_txn(1'b0, 16'h0100, 16'h0000, 2'b00, 1, 16'hC3C3);
    tick();
    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
